// File: rtl/pe_pkg.sv
// Shared types and arithmetic helpers for the systolic MAC processing element.
// Helpers work on a wide scratch width so any ACC_WIDTH up to MAX_W-2 fits.
package pe_pkg;

    localparam int MAX_W = 128;

    typedef enum logic {
        ST_ACCUM = 1'b0,
        ST_DRAIN = 1'b1
    } pe_state_e;

    function automatic logic [MAX_W-1:0] acc_max(input int acc_width, input bit is_signed);
        logic [MAX_W-1:0] ones;
        ones = '1;
        if (is_signed) return ones >> (MAX_W - acc_width + 1);
        return ones >> (MAX_W - acc_width);
    endfunction

    // Signed minimum is returned sign-extended to MAX_W so signed compares work.
    function automatic logic [MAX_W-1:0] acc_min(input int acc_width, input bit is_signed);
        if (is_signed) return ~acc_max(acc_width, 1'b1);
        return '0;
    endfunction

    function automatic logic [MAX_W-1:0] sat_add(
        input  logic [MAX_W-1:0] a,
        input  logic [MAX_W-1:0] b,
        input  int               acc_width,
        input  bit               is_signed,
        input  bit               saturate,
        output logic             ovf
    );
        logic [MAX_W-1:0] sum;
        logic [MAX_W-1:0] hi;
        logic [MAX_W-1:0] lo;
        sum = a + b;
        hi  = acc_max(acc_width, is_signed);
        lo  = acc_min(acc_width, is_signed);
        if (is_signed) ovf = ($signed(sum) > $signed(hi)) || ($signed(sum) < $signed(lo));
        else           ovf = (sum > hi);
        if (ovf && saturate) sum = (is_signed && sum[MAX_W-1]) ? lo : hi;
        return sum;
    endfunction

endpackage

// File: rtl/pe_operand_reg.sv
// One-cycle operand forwarding register (data + valid) with pause hold.
module pe_operand_reg #(
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  pause,
    input  logic [DATA_WIDTH-1:0] d,
    input  logic                  d_valid,
    output logic [DATA_WIDTH-1:0] q,
    output logic                  q_valid
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q       <= '0;
            q_valid <= 1'b0;
        end else if (!pause) begin
            q       <= d;
            q_valid <= d_valid;
        end
    end

endmodule

// File: rtl/pe_mac_drain.sv
// Output-stationary systolic PE: forwards operands, accumulates products, and
// drains its result south through a per-column result chain before self-clearing.
module pe_mac_drain
    import pe_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int ACC_WIDTH  = 40,
    parameter bit SIGNED     = 1'b1,
    parameter bit SATURATE   = 1'b1,
    parameter int DRAIN_LEN  = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  pause,
    input  logic                  clear,
    input  logic                  drain,
    input  logic [DATA_WIDTH-1:0] left_in,
    input  logic                  left_valid_in,
    input  logic [DATA_WIDTH-1:0] top_in,
    input  logic                  top_valid_in,
    output logic [DATA_WIDTH-1:0] right_out,
    output logic                  right_valid_out,
    output logic [DATA_WIDTH-1:0] bottom_out,
    output logic                  bottom_valid_out,
    input  logic [ACC_WIDTH-1:0]  result_in,
    input  logic                  result_valid_in,
    output logic [ACC_WIDTH-1:0]  result_out,
    output logic                  result_valid_out,
    output logic                  busy,
    output logic                  overflow
);

    localparam int PW    = 2 * DATA_WIDTH;
    localparam int CNT_W = (DRAIN_LEN > 1) ? $clog2(DRAIN_LEN) : 1;

    pe_state_e          state, state_n;
    logic [ACC_WIDTH-1:0] acc, acc_n, acc_sum, res_n;
    logic                 ovf_n, res_v_n, mac_ovf;
    logic [CNT_W-1:0]     cnt, cnt_n;
    logic [PW-1:0]        prod;
    logic [MAX_W-1:0]     prod_ext, acc_ext, sum_ext;

    pe_operand_reg #(.DATA_WIDTH(DATA_WIDTH)) u_left_reg (
        .clk(clk), .reset(reset), .pause(pause),
        .d(left_in), .d_valid(left_valid_in),
        .q(right_out), .q_valid(right_valid_out)
    );

    pe_operand_reg #(.DATA_WIDTH(DATA_WIDTH)) u_top_reg (
        .clk(clk), .reset(reset), .pause(pause),
        .d(top_in), .d_valid(top_valid_in),
        .q(bottom_out), .q_valid(bottom_valid_out)
    );

    // Operands are widened to PW first so the product keeps all 2*DATA_WIDTH bits.
    always_comb begin
        if (SIGNED) begin
            prod     = $signed({{DATA_WIDTH{left_in[DATA_WIDTH-1]}}, left_in})
                     * $signed({{DATA_WIDTH{top_in[DATA_WIDTH-1]}}, top_in});
            prod_ext = {{(MAX_W-PW){prod[PW-1]}}, prod};
            acc_ext  = {{(MAX_W-ACC_WIDTH){acc[ACC_WIDTH-1]}}, acc};
        end else begin
            prod     = {{DATA_WIDTH{1'b0}}, left_in} * {{DATA_WIDTH{1'b0}}, top_in};
            prod_ext = {{(MAX_W-PW){1'b0}}, prod};
            acc_ext  = {{(MAX_W-ACC_WIDTH){1'b0}}, acc};
        end
        sum_ext = sat_add(acc_ext, prod_ext, ACC_WIDTH, SIGNED, SATURATE, mac_ovf);
        acc_sum = ACC_WIDTH'(sum_ext);
    end

    // Drain wins over clear and MAC; the drain edge emits the pre-clear accumulator.
    always_comb begin
        state_n = state;
        acc_n   = acc;
        ovf_n   = overflow;
        cnt_n   = cnt;
        res_n   = result_out;
        res_v_n = result_valid_out;
        case (state)
            ST_ACCUM: begin
                res_v_n = 1'b0;
                if (drain) begin
                    state_n = ST_DRAIN;
                    res_n   = acc;
                    res_v_n = 1'b1;
                    cnt_n   = CNT_W'(DRAIN_LEN - 1);
                end else if (clear) begin
                    acc_n = '0;
                    ovf_n = 1'b0;
                end else if (left_valid_in && top_valid_in) begin
                    acc_n = acc_sum;
                    ovf_n = overflow | mac_ovf;
                end
            end
            ST_DRAIN: begin
                if (cnt == '0) begin
                    state_n = ST_ACCUM;
                    acc_n   = '0;
                    ovf_n   = 1'b0;
                    res_v_n = 1'b0;
                end else begin
                    res_n   = result_in;
                    res_v_n = result_valid_in;
                    cnt_n   = cnt - CNT_W'(1);
                end
            end
            default: state_n = ST_ACCUM;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state            <= ST_ACCUM;
            acc              <= '0;
            overflow         <= 1'b0;
            cnt              <= '0;
            result_out       <= '0;
            result_valid_out <= 1'b0;
        end else if (!pause) begin
            state            <= state_n;
            acc              <= acc_n;
            overflow         <= ovf_n;
            cnt              <= cnt_n;
            result_out       <= res_n;
            result_valid_out <= res_v_n;
        end
    end

    assign busy = (state == ST_DRAIN);

endmodule

// File: tb/tb_pe_mac_drain.sv
// Directed bench for pe_mac_drain: single cells in several configurations plus a 4-cell column.
module tb_pe_mac_drain;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    logic [39:0] exp_q[$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- group A: default cell, DRAIN_LEN=1 ----------------
    logic        a_pause, a_clear, a_drain, a_lv, a_tv;
    logic [15:0] a_left, a_top, a_right, a_bottom;
    logic        a_rv, a_bv, a_resv, a_busy, a_ovf;
    logic [39:0] a_res;
    logic [39:0] a_res_in = '0;
    logic        a_res_in_v = 1'b0;

    pe_mac_drain #(.DATA_WIDTH(16), .ACC_WIDTH(40), .SIGNED(1'b1), .SATURATE(1'b1), .DRAIN_LEN(1)) u_a (
        .clk(clk), .reset(rst), .pause(a_pause), .clear(a_clear), .drain(a_drain),
        .left_in(a_left), .left_valid_in(a_lv), .top_in(a_top), .top_valid_in(a_tv),
        .right_out(a_right), .right_valid_out(a_rv), .bottom_out(a_bottom), .bottom_valid_out(a_bv),
        .result_in(a_res_in), .result_valid_in(a_res_in_v), .result_out(a_res), .result_valid_out(a_resv),
        .busy(a_busy), .overflow(a_ovf)
    );

    // ---------------- group S: 32-bit saturating vs wrapping ----------------
    logic        s_pause, s_clear, s_drain, s_lv, s_tv;
    logic [15:0] s_left, s_top;
    logic [31:0] s_res_in = '0;
    logic        s_res_in_v = 1'b0;
    logic [15:0] sat_right, sat_bottom, wrap_right, wrap_bottom;
    logic        sat_rv, sat_bv, wrap_rv, wrap_bv;
    logic [31:0] sat_res, wrap_res;
    logic        sat_resv, sat_busy, sat_ovf, wrap_resv, wrap_busy, wrap_ovf;

    pe_mac_drain #(.DATA_WIDTH(16), .ACC_WIDTH(32), .SIGNED(1'b1), .SATURATE(1'b1), .DRAIN_LEN(1)) u_sat (
        .clk(clk), .reset(rst), .pause(s_pause), .clear(s_clear), .drain(s_drain),
        .left_in(s_left), .left_valid_in(s_lv), .top_in(s_top), .top_valid_in(s_tv),
        .right_out(sat_right), .right_valid_out(sat_rv), .bottom_out(sat_bottom), .bottom_valid_out(sat_bv),
        .result_in(s_res_in), .result_valid_in(s_res_in_v), .result_out(sat_res), .result_valid_out(sat_resv),
        .busy(sat_busy), .overflow(sat_ovf)
    );

    pe_mac_drain #(.DATA_WIDTH(16), .ACC_WIDTH(32), .SIGNED(1'b1), .SATURATE(1'b0), .DRAIN_LEN(1)) u_wrap (
        .clk(clk), .reset(rst), .pause(s_pause), .clear(s_clear), .drain(s_drain),
        .left_in(s_left), .left_valid_in(s_lv), .top_in(s_top), .top_valid_in(s_tv),
        .right_out(wrap_right), .right_valid_out(wrap_rv), .bottom_out(wrap_bottom), .bottom_valid_out(wrap_bv),
        .result_in(s_res_in), .result_valid_in(s_res_in_v), .result_out(wrap_res), .result_valid_out(wrap_resv),
        .busy(wrap_busy), .overflow(wrap_ovf)
    );

    // ---------------- group C: 4-cell column, index 0 = bottom ----------------
    logic        c_pause, c_clear, c_drain, c_tv;
    logic [15:0] c_top;
    logic [15:0] col_left [0:3];
    logic        col_lv   [0:3];
    logic [15:0] col_right [0:3];
    logic [15:0] col_bottom [0:3];
    logic        col_rv [0:3];
    logic        col_bv [0:3];
    logic        col_busy [0:3];
    logic        col_ovf [0:3];
    logic [39:0] col_res [0:4];
    logic        col_resv [0:4];

    assign col_res[4]  = '0;
    assign col_resv[4] = 1'b0;

    for (genvar g = 0; g < 4; g++) begin : g_col
        pe_mac_drain #(.DATA_WIDTH(16), .ACC_WIDTH(40), .SIGNED(1'b1), .SATURATE(1'b1), .DRAIN_LEN(4 - g)) u_cell (
            .clk(clk), .reset(rst), .pause(c_pause), .clear(c_clear), .drain(c_drain),
            .left_in(col_left[g]), .left_valid_in(col_lv[g]), .top_in(c_top), .top_valid_in(c_tv),
            .right_out(col_right[g]), .right_valid_out(col_rv[g]),
            .bottom_out(col_bottom[g]), .bottom_valid_out(col_bv[g]),
            .result_in(col_res[g+1]), .result_valid_in(col_resv[g+1]),
            .result_out(col_res[g]), .result_valid_out(col_resv[g]),
            .busy(col_busy[g]), .overflow(col_ovf[g])
        );
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        a_pause = 0; a_clear = 0; a_drain = 0; a_lv = 0; a_tv = 0; a_left = '0; a_top = '0;
        s_pause = 0; s_clear = 0; s_drain = 0; s_lv = 0; s_tv = 0; s_left = '0; s_top = '0;
        c_pause = 0; c_clear = 0; c_drain = 0; c_tv = 0; c_top = '0;
        for (int i = 0; i < 4; i++) begin
            col_left[i] = '0;
            col_lv[i]   = 1'b0;
        end
        repeat (2) tick();
        check("rst_right", 64'(a_right), 64'(0));
        check("rst_rvalid", 64'(a_rv), 64'(0));
        check("rst_result", 64'(a_res), 64'(0));
        check("rst_resvalid", 64'(a_resv), 64'(0));
        check("rst_busy", 64'(a_busy), 64'(0));
        check("rst_ovf", 64'(a_ovf), 64'(0));
        rst = 1'b0;
        tick();

        // forwarding and pause hold
        a_left = 16'h0003; a_lv = 1'b1;
        tick();
        check("fwd_right", 64'(a_right), 64'(16'h0003));
        check("fwd_rvalid", 64'(a_rv), 64'(1));
        a_pause = 1'b1; a_left = 16'h0009; a_lv = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("pause_right", 64'(a_right), 64'(16'h0003));
            check("pause_rvalid", 64'(a_rv), 64'(1));
        end
        a_pause = 1'b0;
        tick();
        check("unpause_right", 64'(a_right), 64'(16'h0009));
        check("unpause_rvalid", 64'(a_rv), 64'(0));
        a_top = 16'h0007; a_tv = 1'b1;
        tick();
        check("fwd_bottom", 64'(a_bottom), 64'(16'h0007));
        check("fwd_bvalid", 64'(a_bv), 64'(1));
        a_tv = 1'b0;

        // signed MAC: 4 x (-3 * 5) = -60
        a_left = 16'hFFFD; a_top = 16'd5; a_lv = 1'b1; a_tv = 1'b1;
        repeat (4) tick();
        a_lv = 1'b0; a_tv = 1'b0;
        check("mac_ovf", 64'(a_ovf), 64'(0));
        a_drain = 1'b1;
        tick();
        a_drain = 1'b0;
        check("mac_result", 64'(a_res), 64'(40'hFFFFFFFFC4));
        check("mac_resvalid", 64'(a_resv), 64'(1));
        check("mac_busy", 64'(a_busy), 64'(1));
        a_left = 16'd100; a_top = 16'd100; a_lv = 1'b1; a_tv = 1'b1;
        tick();
        a_lv = 1'b0; a_tv = 1'b0;
        check("drain_end_resvalid", 64'(a_resv), 64'(0));
        check("drain_end_busy", 64'(a_busy), 64'(0));
        check("drain_end_hold", 64'(a_res), 64'(40'hFFFFFFFFC4));
        a_drain = 1'b1;
        tick();
        a_drain = 1'b0;
        check("self_clear_result", 64'(a_res), 64'(0));
        tick();

        // drain and clear together: pre-clear value is emitted
        a_left = 16'd7; a_top = 16'd1; a_lv = 1'b1; a_tv = 1'b1;
        tick();
        a_lv = 1'b0; a_tv = 1'b0;
        a_drain = 1'b1; a_clear = 1'b1;
        tick();
        a_drain = 1'b0; a_clear = 1'b0;
        check("drain_clear_result", 64'(a_res), 64'(7));
        check("drain_clear_valid", 64'(a_resv), 64'(1));
        tick();
        check("drain_clear_done", 64'(a_resv), 64'(0));

        // pause mid-drain stretches the output
        a_left = 16'd3; a_top = 16'd3; a_lv = 1'b1; a_tv = 1'b1;
        tick();
        a_lv = 1'b0; a_tv = 1'b0;
        a_drain = 1'b1;
        tick();
        a_drain = 1'b0;
        check("pdrain_result", 64'(a_res), 64'(9));
        a_pause = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            check("pdrain_hold_valid", 64'(a_resv), 64'(1));
            check("pdrain_hold_busy", 64'(a_busy), 64'(1));
            check("pdrain_hold_result", 64'(a_res), 64'(9));
        end
        a_pause = 1'b0;
        tick();
        check("pdrain_end_valid", 64'(a_resv), 64'(0));
        check("pdrain_end_busy", 64'(a_busy), 64'(0));

        // saturation vs wrap at ACC_WIDTH=32
        s_left = 16'h7FFF; s_top = 16'h7FFF; s_lv = 1'b1; s_tv = 1'b1;
        repeat (2) tick();
        check("sat_no_ovf_yet", 64'(sat_ovf), 64'(0));
        check("wrap_no_ovf_yet", 64'(wrap_ovf), 64'(0));
        tick();
        s_lv = 1'b0; s_tv = 1'b0;
        check("sat_ovf", 64'(sat_ovf), 64'(1));
        check("wrap_ovf", 64'(wrap_ovf), 64'(1));
        s_drain = 1'b1;
        tick();
        s_drain = 1'b0;
        check("sat_result", 64'(sat_res), 64'(32'h7FFFFFFF));
        check("wrap_result", 64'(wrap_res), 64'(32'hBFFD0003));
        tick();
        check("sat_ovf_cleared", 64'(sat_ovf), 64'(0));
        check("wrap_ovf_cleared", 64'(wrap_ovf), 64'(0));

        // column: preload 10,20,30,40 bottom..top, drain all together
        for (int i = 0; i < 4; i++) begin
            col_left[i] = 16'(10 * (i + 1));
            col_lv[i]   = 1'b1;
        end
        c_top = 16'd1; c_tv = 1'b1;
        tick();
        for (int i = 0; i < 4; i++) col_lv[i] = 1'b0;
        c_tv = 1'b0;
        for (int i = 0; i < 4; i++) exp_q.push_back(40'(10 * (i + 1)));
        c_drain = 1'b1;
        tick();
        c_drain = 1'b0;
        for (int k = 0; k < 4; k++) begin
            check("col_result", 64'(col_res[0]), 64'(exp_q.pop_front()));
            check("col_valid", 64'(col_resv[0]), 64'(1));
            tick();
        end
        check("col_done_valid", 64'(col_resv[0]), 64'(0));
        check("col_done_busy", 64'(col_busy[0]), 64'(0));
        for (int i = 0; i < 4; i++) exp_q.push_back(40'(0));
        c_drain = 1'b1;
        tick();
        c_drain = 1'b0;
        for (int k = 0; k < 4; k++) begin
            check("col_cleared", 64'(col_res[0]), 64'(exp_q.pop_front()));
            tick();
        end

        // asynchronous reset in the middle of a drain
        a_left = 16'd2; a_top = 16'd2; a_lv = 1'b1; a_tv = 1'b1;
        tick();
        a_left = 16'd5; a_tv = 1'b0; a_drain = 1'b1;
        tick();
        a_drain = 1'b0;
        check("pre_rst_busy", 64'(a_busy), 64'(1));
        check("pre_rst_right", 64'(a_right), 64'(16'd5));
        rst = 1'b1;
        #1;
        check("async_rst_right", 64'(a_right), 64'(0));
        check("async_rst_rvalid", 64'(a_rv), 64'(0));
        check("async_rst_result", 64'(a_res), 64'(0));
        check("async_rst_resvalid", 64'(a_resv), 64'(0));
        check("async_rst_busy", 64'(a_busy), 64'(0));
        #2;
        rst = 1'b0;
        a_lv = 1'b0;
        tick();
        a_drain = 1'b1;
        tick();
        a_drain = 1'b0;
        check("post_rst_acc", 64'(a_res), 64'(0));
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
